// File: rtl/wr_port_arb_8to1_pkg.sv
// Shared widths, payload type and helpers for the 8-to-1 register-file write port arbiter.
package wr_port_arb_8to1_pkg;

    localparam int unsigned NUM_PORTS = 8;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 2048;  // 64 lanes x 32 bits
    localparam int unsigned MASK_W    = 64;    // one enable per lane
    localparam int unsigned PTR_W     = 3;

    // One buffered write request.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
    } wr_req_t;

    // Round-robin pointer step: one past the granted port, wrapping at 8.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return PTR_W'(idx + PTR_W'(1));
    endfunction

endpackage

// File: rtl/wr_port_rr_arbiter_8.sv
// Combinational 8-way round-robin arbiter.
//   req       : per-port request (holding buffer valid)
//   ptr       : highest-priority port for this cycle
//   grant     : one-hot grant, zero when no request
//   grant_idx : index of the granted port (0 when no request)
module wr_port_rr_arbiter_8
    import wr_port_arb_8to1_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PTR_W-1:0]     grant_idx
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the ports starting at ptr; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = PTR_W'(ptr + PTR_W'(i));
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wr_port_arb_8to1.sv
// Eight requesters share one register-file write port. Each port has a one-entry
// holding buffer; a round-robin arbiter picks one valid buffer per cycle and its
// contents are registered onto the muxed write port.
//   clk, rst                  : clock, synchronous active-high reset
//   portK_wr_en/addr/data/mask: write request from requester K (K = 0..7)
//   portK_wr_ready            : request K is taken this cycle if portK_wr_en is high
//   muxed_port_wr_*           : registered single-cycle write to the register file
//   wr_busy                   : any holding buffer valid
module wr_port_arb_8to1
    import wr_port_arb_8to1_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              port0_wr_en,
    input  logic [ADDR_W-1:0] port0_wr_addr,
    input  logic [DATA_W-1:0] port0_wr_data,
    input  logic [MASK_W-1:0] port0_wr_mask,
    output logic              port0_wr_ready,

    input  logic              port1_wr_en,
    input  logic [ADDR_W-1:0] port1_wr_addr,
    input  logic [DATA_W-1:0] port1_wr_data,
    input  logic [MASK_W-1:0] port1_wr_mask,
    output logic              port1_wr_ready,

    input  logic              port2_wr_en,
    input  logic [ADDR_W-1:0] port2_wr_addr,
    input  logic [DATA_W-1:0] port2_wr_data,
    input  logic [MASK_W-1:0] port2_wr_mask,
    output logic              port2_wr_ready,

    input  logic              port3_wr_en,
    input  logic [ADDR_W-1:0] port3_wr_addr,
    input  logic [DATA_W-1:0] port3_wr_data,
    input  logic [MASK_W-1:0] port3_wr_mask,
    output logic              port3_wr_ready,

    input  logic              port4_wr_en,
    input  logic [ADDR_W-1:0] port4_wr_addr,
    input  logic [DATA_W-1:0] port4_wr_data,
    input  logic [MASK_W-1:0] port4_wr_mask,
    output logic              port4_wr_ready,

    input  logic              port5_wr_en,
    input  logic [ADDR_W-1:0] port5_wr_addr,
    input  logic [DATA_W-1:0] port5_wr_data,
    input  logic [MASK_W-1:0] port5_wr_mask,
    output logic              port5_wr_ready,

    input  logic              port6_wr_en,
    input  logic [ADDR_W-1:0] port6_wr_addr,
    input  logic [DATA_W-1:0] port6_wr_data,
    input  logic [MASK_W-1:0] port6_wr_mask,
    output logic              port6_wr_ready,

    input  logic              port7_wr_en,
    input  logic [ADDR_W-1:0] port7_wr_addr,
    input  logic [DATA_W-1:0] port7_wr_data,
    input  logic [MASK_W-1:0] port7_wr_mask,
    output logic              port7_wr_ready,

    output logic              muxed_port_wr_en,
    output logic [ADDR_W-1:0] muxed_port_wr_addr,
    output logic [DATA_W-1:0] muxed_port_wr_data,
    output logic [MASK_W-1:0] muxed_port_wr_mask,
    output logic              wr_busy
);

    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] ready;
    logic [NUM_PORTS-1:0] accept;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] hold_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     rr_ptr;
    logic                 any_grant;
    logic                 out_en;
    wr_req_t              out_q;
    wr_req_t              wr_in    [NUM_PORTS];
    wr_req_t              hold_buf [NUM_PORTS];

    // Gather the flat per-port inputs into indexable form.
    assign wr_en = {port7_wr_en, port6_wr_en, port5_wr_en, port4_wr_en,
                    port3_wr_en, port2_wr_en, port1_wr_en, port0_wr_en};

    assign wr_in[0] = '{addr: port0_wr_addr, data: port0_wr_data, mask: port0_wr_mask};
    assign wr_in[1] = '{addr: port1_wr_addr, data: port1_wr_data, mask: port1_wr_mask};
    assign wr_in[2] = '{addr: port2_wr_addr, data: port2_wr_data, mask: port2_wr_mask};
    assign wr_in[3] = '{addr: port3_wr_addr, data: port3_wr_data, mask: port3_wr_mask};
    assign wr_in[4] = '{addr: port4_wr_addr, data: port4_wr_data, mask: port4_wr_mask};
    assign wr_in[5] = '{addr: port5_wr_addr, data: port5_wr_data, mask: port5_wr_mask};
    assign wr_in[6] = '{addr: port6_wr_addr, data: port6_wr_data, mask: port6_wr_mask};
    assign wr_in[7] = '{addr: port7_wr_addr, data: port7_wr_data, mask: port7_wr_mask};

    wr_port_rr_arbiter_8 u_arb (
        .req       (hold_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready depends only on registered state: a granted buffer empties this edge,
    // so it can take a new write without a bubble.
    assign ready     = ~hold_valid | grant;
    assign accept    = wr_en & ready;
    assign any_grant = |grant;

    // Buffer valid bits, round-robin pointer and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
            out_en     <= 1'b0;
            out_q      <= '0;
        end else begin
            hold_valid <= accept | (hold_valid & ~grant);
            out_en     <= any_grant;
            if (any_grant) begin
                out_q  <= hold_buf[grant_idx];
                rr_ptr <= next_ptr(grant_idx);
            end
        end
    end

    // Buffer payloads are only read while valid, so they carry no reset.
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_buf
        always_ff @(posedge clk) begin
            if (accept[k]) begin
                hold_buf[k] <= wr_in[k];
            end
        end
    end

    assign port0_wr_ready = ready[0];
    assign port1_wr_ready = ready[1];
    assign port2_wr_ready = ready[2];
    assign port3_wr_ready = ready[3];
    assign port4_wr_ready = ready[4];
    assign port5_wr_ready = ready[5];
    assign port6_wr_ready = ready[6];
    assign port7_wr_ready = ready[7];

    assign muxed_port_wr_en   = out_en;
    assign muxed_port_wr_addr = out_q.addr;
    assign muxed_port_wr_data = out_q.data;
    assign muxed_port_wr_mask = out_q.mask;
    assign wr_busy            = |hold_valid;

endmodule

// File: tb/tb_wr_port_arb_8to1.sv
// Bench for wr_port_arb_8to1: table of single writes plus multi-cycle sequences,
// with a scoreboard queue checked on every muxed write strobe.
module tb_wr_port_arb_8to1;

    typedef struct {
        logic [9:0]    addr;
        logic [2047:0] data;
        logic [63:0]   mask;
    } exp_t;

    typedef struct {
        int          port;
        logic [9:0]  addr;
        logic [31:0] word;
        logic [63:0] mask;
        int          exp_lat;
        int          exp_strobes;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [7:0]    en;
    logic [9:0]    addr [8];
    logic [2047:0] data [8];
    logic [63:0]   mask [8];
    wire  [7:0]    rdy;
    logic          m_en;
    logic [9:0]    m_addr;
    logic [2047:0] m_data;
    logic [63:0]   m_mask;
    logic          busy;

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    exp_t exp_q[$];
    int   strobe_cyc[$];

    wr_port_arb_8to1 dut (
        .clk(clk), .rst(rst),
        .port0_wr_en(en[0]), .port0_wr_addr(addr[0]), .port0_wr_data(data[0]), .port0_wr_mask(mask[0]), .port0_wr_ready(rdy[0]),
        .port1_wr_en(en[1]), .port1_wr_addr(addr[1]), .port1_wr_data(data[1]), .port1_wr_mask(mask[1]), .port1_wr_ready(rdy[1]),
        .port2_wr_en(en[2]), .port2_wr_addr(addr[2]), .port2_wr_data(data[2]), .port2_wr_mask(mask[2]), .port2_wr_ready(rdy[2]),
        .port3_wr_en(en[3]), .port3_wr_addr(addr[3]), .port3_wr_data(data[3]), .port3_wr_mask(mask[3]), .port3_wr_ready(rdy[3]),
        .port4_wr_en(en[4]), .port4_wr_addr(addr[4]), .port4_wr_data(data[4]), .port4_wr_mask(mask[4]), .port4_wr_ready(rdy[4]),
        .port5_wr_en(en[5]), .port5_wr_addr(addr[5]), .port5_wr_data(data[5]), .port5_wr_mask(mask[5]), .port5_wr_ready(rdy[5]),
        .port6_wr_en(en[6]), .port6_wr_addr(addr[6]), .port6_wr_data(data[6]), .port6_wr_mask(mask[6]), .port6_wr_ready(rdy[6]),
        .port7_wr_en(en[7]), .port7_wr_addr(addr[7]), .port7_wr_data(data[7]), .port7_wr_mask(mask[7]), .port7_wr_ready(rdy[7]),
        .muxed_port_wr_en(m_en), .muxed_port_wr_addr(m_addr), .muxed_port_wr_data(m_data),
        .muxed_port_wr_mask(m_mask), .wr_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [2047:0] rep(input logic [31:0] w);
        return {64{w}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (m_en) begin
            exp_t e;
            strobe_cyc.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: got addr=%0h data_lo=%0h, expected no strobe", m_addr, m_data[31:0]);
            end else begin
                e = exp_q.pop_front();
                if (m_addr !== e.addr || m_data !== e.data || m_mask !== e.mask) begin
                    miscompares++;
                    $display("FAIL strobe_payload: got addr=%0h data_lo=%0h mask=%0h expected addr=%0h data_lo=%0h mask=%0h",
                             m_addr, m_data[31:0], m_mask, e.addr, e.data[31:0], e.mask);
                end
            end
        end
    end

    task automatic idle_inputs();
        en = '0;
        for (int k = 0; k < 8; k++) begin
            addr[k] = '0;
            data[k] = '0;
            mask[k] = '0;
        end
    endtask

    // Called at a negedge; returns at a negedge with rst low.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        strobe_cyc.delete();
    endtask

    // Present one write on port k until ready; acc = cycle in which it is accepted.
    task automatic submit(input int k, input logic [9:0] a, input logic [2047:0] d,
                          input logic [63:0] m, output int acc);
        int n = 0;
        en[k] = 1'b1; addr[k] = a; data[k] = d; mask[k] = m;
        while (!rdy[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!rdy[k]) begin
            vectors++;
            miscompares++;
            $display("FAIL submit_timeout: port %0d ready stayed 0, expected 1", k);
        end else begin
            exp_q.push_back('{a, d, m});
        end
        @(negedge clk);
        en[k] = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || m_en) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int acc;
        int n1, n6, w1, w6, max1, max6;

        vecs[0] = '{0, 10'h000, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1};
        vecs[1] = '{3, 10'h05A, 32'hA5A5_A5A5, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1};
        vecs[2] = '{7, 10'h3FF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 2, 1};
        vecs[3] = '{1, 10'h155, 32'h1234_5678, 64'h5555_5555_5555_5555, 2, 1};
        vecs[4] = '{6, 10'h2AA, 32'hDEAD_BEEF, 64'hAAAA_AAAA_AAAA_AAAA, 2, 1};
        vecs[5] = '{2, 10'h001, 32'h0F0F_0F0F, 64'h0000_0000_0000_0001, 2, 1};
        vecs[6] = '{4, 10'h200, 32'h8000_0001, 64'h8000_0000_0000_0000, 2, 1};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state, first cycle after release.
        chk("rst_en", 64'(m_en), 64'd0);
        chk("rst_addr", 64'(m_addr), 64'd0);
        chk("rst_data_nonzero", 64'(m_data != '0), 64'd0);
        chk("rst_mask", m_mask, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(rdy), 64'hFF);

        // Table of isolated writes: latency 2, one strobe, pass-through, idle hold.
        for (int i = 0; i < 7; i++) begin
            strobe_cyc.delete();
            submit(vecs[i].port, vecs[i].addr, rep(vecs[i].word), vecs[i].mask, acc);
            drain($sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_strobes", i), 64'(strobe_cyc.size()), 64'(vecs[i].exp_strobes));
            if (strobe_cyc.size() > 0)
                chk($sformatf("vec%0d_latency", i), 64'(strobe_cyc[0] - acc), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_idle_en", i), 64'(m_en), 64'd0);
            chk($sformatf("vec%0d_idle_addr", i), 64'(m_addr), 64'(vecs[i].addr));
            chk($sformatf("vec%0d_idle_mask", i), m_mask, vecs[i].mask);
        end

        // All eight ports at once after reset: issue order 0..7 on consecutive cycles.
        do_reset();
        chk("all8_ready", 64'(rdy), 64'hFF);
        for (int k = 0; k < 8; k++) begin
            en[k] = 1'b1; addr[k] = 10'(k); data[k] = rep(32'h1000 + 32'(k)); mask[k] = {8{8'(1 << k)}};
        end
        acc = cyc;
        for (int k = 0; k < 8; k++) exp_q.push_back('{10'(k), rep(32'h1000 + 32'(k)), {8{8'(1 << k)}}});
        @(negedge clk);
        en = '0;
        drain("all8");
        chk("all8_strobes", 64'(strobe_cyc.size()), 64'd8);
        for (int i = 0; i < 8 && i < strobe_cyc.size(); i++)
            chk($sformatf("all8_cycle%0d", i), 64'(strobe_cyc[i] - acc), 64'(2 + i));

        // Port 5 writes every cycle: ready stays high, 16 back-to-back strobes.
        strobe_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            en[5] = 1'b1; addr[5] = 10'(i); data[5] = rep(32'h5000 + 32'(i)); mask[5] = '1;
            chk($sformatf("b2b_ready%0d", i), 64'(rdy[5]), 64'd1);
            if (i == 0) acc = cyc;
            exp_q.push_back('{10'(i), rep(32'h5000 + 32'(i)), 64'hFFFF_FFFF_FFFF_FFFF});
            @(negedge clk);
        end
        en[5] = 1'b0;
        drain("b2b");
        chk("b2b_strobes", 64'(strobe_cyc.size()), 64'd16);
        for (int i = 0; i < 16 && i < strobe_cyc.size(); i++)
            chk($sformatf("b2b_cycle%0d", i), 64'(strobe_cyc[i] - acc), 64'(2 + i));

        // Ports 1 and 6 both streaming from rr_ptr=0: issues alternate 1,6,1,6.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{10'(32'h100 + 32'(i)), rep(32'h1100 + 32'(i)), 64'hFFFF_FFFF_FFFF_FFFF});
            exp_q.push_back('{10'(32'h200 + 32'(i)), rep(32'h6600 + 32'(i)), 64'hFFFF_FFFF_FFFF_FFFF});
        end
        n1 = 0; n6 = 0; w1 = 0; w6 = 0; max1 = 0; max6 = 0;
        for (int c = 0; c < 40 && (n1 < 6 || n6 < 6); c++) begin
            en[1] = (n1 < 6); addr[1] = 10'(32'h100 + 32'(n1)); data[1] = rep(32'h1100 + 32'(n1)); mask[1] = '1;
            en[6] = (n6 < 6); addr[6] = 10'(32'h200 + 32'(n6)); data[6] = rep(32'h6600 + 32'(n6)); mask[6] = '1;
            if (en[1]) begin
                if (rdy[1]) begin n1++; w1 = 0; end
                else begin w1++; if (w1 > max1) max1 = w1; end
            end
            if (en[6]) begin
                if (rdy[6]) begin n6++; w6 = 0; end
                else begin w6++; if (w6 > max6) max6 = w6; end
            end
            @(negedge clk);
        end
        en = '0;
        drain("alt16");
        chk("alt_p1_count", 64'(n1), 64'd6);
        chk("alt_p6_count", 64'(n6), 64'd6);
        chk("alt_p1_wait_le2", 64'(max1 > 2), 64'd0);
        chk("alt_p6_wait_le2", 64'(max6 > 2), 64'd0);

        // Reset one cycle after four acceptances: nothing is issued.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            en[k] = 1'b1; addr[k] = 10'(32'h300 + 32'(k)); data[k] = rep(32'h7700 + 32'(k)); mask[k] = '1;
        end
        chk("rstmid_ready", 64'(rdy), 64'hFF);
        @(negedge clk);
        en = '0;
        chk("rstmid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_en", 64'(m_en), 64'd0);
        chk("rstmid_addr", 64'(m_addr), 64'd0);
        chk("rstmid_data_nonzero", 64'(m_data != '0), 64'd0);
        chk("rstmid_mask", m_mask, 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_ready_after", 64'(rdy), 64'hFF);
        repeat (10) @(negedge clk);
        chk("rstmid_no_strobe", 64'(strobe_cyc.size()), 64'd0);

        // Same address from ports 2 and 4 with rr_ptr=3: port 4 first, port 2 last.
        do_reset();
        submit(2, 10'h010, rep(32'h2222_0000), '1, acc);
        drain("ptr3_setup");
        en[2] = 1'b1; addr[2] = 10'h3FF; data[2] = rep(32'hCAFE_0002); mask[2] = '1;
        en[4] = 1'b1; addr[4] = 10'h3FF; data[4] = rep(32'hBEEF_0004); mask[4] = '1;
        exp_q.push_back('{10'h3FF, rep(32'hBEEF_0004), 64'hFFFF_FFFF_FFFF_FFFF});
        exp_q.push_back('{10'h3FF, rep(32'hCAFE_0002), 64'hFFFF_FFFF_FFFF_FFFF});
        @(negedge clk);
        en = '0;
        drain("same_addr");
        chk("same_addr_last_data", 64'(m_data[31:0]), 64'hCAFE_0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
